// File: rtl/issue_scheduler_if.sv
// Signal bundle joining the issue scheduler to the decoder, rename register file,
// ROB, RS, LSB and CDB.
interface issue_scheduler_if #(
    parameter int DATA_W    = 32,
    parameter int ROB_POS_W = 4,
    parameter int OP_W      = 6
);
    logic                 rdy;
    logic                 rollback;
    logic                 in_valid;
    logic                 in_ready;
    logic [OP_W-1:0]      in_op;
    logic                 in_is_ls;
    logic [4:0]           in_rd;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic                 in_use_rs1;
    logic                 in_use_rs2;
    logic [DATA_W-1:0]    in_imm;
    logic [DATA_W-1:0]    in_pc;
    logic                 rob_full;
    logic [ROB_POS_W-1:0] rob_tail;
    logic                 rs_full;
    logic                 lsb_full;
    logic [4:0]           rf_rs1;
    logic [4:0]           rf_rs2;
    logic [DATA_W-1:0]    rf_val1;
    logic [DATA_W-1:0]    rf_val2;
    logic [ROB_POS_W:0]   rf_rob_id1;
    logic [ROB_POS_W:0]   rf_rob_id2;
    logic                 rf_issue;
    logic [4:0]           rf_issue_rd;
    logic [ROB_POS_W-1:0] rf_issue_rob_pos;
    logic                 cdb_valid;
    logic [ROB_POS_W-1:0] cdb_rob_pos;
    logic [DATA_W-1:0]    cdb_val;
    logic                 rs_disp;
    logic                 lsb_disp;
    logic [OP_W-1:0]      d_op;
    logic [DATA_W-1:0]    d_imm;
    logic [DATA_W-1:0]    d_pc;
    logic [4:0]           d_rd;
    logic [ROB_POS_W-1:0] d_rob_pos;
    logic [ROB_POS_W:0]   d_q1;
    logic [ROB_POS_W:0]   d_q2;
    logic [DATA_W-1:0]    d_v1;
    logic [DATA_W-1:0]    d_v2;
    logic [31:0]          issue_cnt;

    modport slave (
        input  rdy, rollback, in_valid, in_op, in_is_ls, in_rd, in_rs1, in_rs2,
               in_use_rs1, in_use_rs2, in_imm, in_pc, rob_full, rob_tail,
               rs_full, lsb_full, rf_val1, rf_val2, rf_rob_id1, rf_rob_id2,
               cdb_valid, cdb_rob_pos, cdb_val,
        output in_ready, rf_rs1, rf_rs2, rf_issue, rf_issue_rd, rf_issue_rob_pos,
               rs_disp, lsb_disp, d_op, d_imm, d_pc, d_rd, d_rob_pos,
               d_q1, d_q2, d_v1, d_v2, issue_cnt
    );

    modport master (
        output rdy, rollback, in_valid, in_op, in_is_ls, in_rd, in_rs1, in_rs2,
               in_use_rs1, in_use_rs2, in_imm, in_pc, rob_full, rob_tail,
               rs_full, lsb_full, rf_val1, rf_val2, rf_rob_id1, rf_rob_id2,
               cdb_valid, cdb_rob_pos, cdb_val,
        input  in_ready, rf_rs1, rf_rs2, rf_issue, rf_issue_rd, rf_issue_rob_pos,
               rs_disp, lsb_disp, d_op, d_imm, d_pc, d_rd, d_rob_pos,
               d_q1, d_q2, d_v1, d_v2, issue_cnt
    );
endinterface

// File: rtl/issue_scheduler.sv
// Single-entry issue stage: holds one decoded instruction, renames it into the ROB when
// resources allow, and presents a registered dispatch packet to the RS or LSB a cycle later.
module issue_scheduler #(
    parameter int DATA_W    = 32,
    parameter int ROB_POS_W = 4,
    parameter int OP_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    issue_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;

    logic [OP_W-1:0]      op_r;
    logic                 is_ls_r;
    logic [4:0]           rd_r;
    logic [4:0]           rs1_r;
    logic [4:0]           rs2_r;
    logic                 use1_r;
    logic                 use2_r;
    logic [DATA_W-1:0]    imm_r;
    logic [DATA_W-1:0]    pc_r;

    logic                 tgt_full_s;
    logic                 fire_s;
    logic                 ready_s;
    logic                 accept_s;
    logic [ROB_POS_W:0]   q1_s;
    logic [ROB_POS_W:0]   q2_s;
    logic [DATA_W-1:0]    v1_s;
    logic [DATA_W-1:0]    v2_s;

    logic                 rs_disp_r;
    logic                 lsb_disp_r;
    logic [OP_W-1:0]      d_op_r;
    logic [DATA_W-1:0]    d_imm_r;
    logic [DATA_W-1:0]    d_pc_r;
    logic [4:0]           d_rd_r;
    logic [ROB_POS_W-1:0] d_rob_pos_r;
    logic [ROB_POS_W:0]   d_q1_r;
    logic [ROB_POS_W:0]   d_q2_r;
    logic [DATA_W-1:0]    d_v1_r;
    logic [DATA_W-1:0]    d_v2_r;
    logic [31:0]          issue_cnt_r;

    // A busy tag whose producer broadcasts on the CDB this very cycle resolves to the CDB value.
    function automatic logic [ROB_POS_W+DATA_W:0] resolve_operand(
        input logic                 use_op,
        input logic [4:0]           idx,
        input logic [ROB_POS_W:0]   rob_id,
        input logic [DATA_W-1:0]    rf_val,
        input logic                 cdb_v,
        input logic [ROB_POS_W-1:0] cdb_pos,
        input logic [DATA_W-1:0]    cdb_d
    );
        logic [ROB_POS_W+DATA_W:0] res;
        if (!use_op || (idx == 5'd0)) begin
            res = '0;
        end else if (rob_id[ROB_POS_W] && cdb_v && (rob_id[ROB_POS_W-1:0] == cdb_pos)) begin
            res = {{(ROB_POS_W+1){1'b0}}, cdb_d};
        end else begin
            res = {rob_id, rf_val};
        end
        return res;
    endfunction

    // Issue handshake: fire, accept and operand resolution for the held instruction.
    always_comb begin
        tgt_full_s = is_ls_r ? bus.lsb_full : bus.rs_full;
        fire_s     = bus.rdy & (state_r == ST_HOLD) & ~bus.rollback & ~bus.rob_full & ~tgt_full_s;
        ready_s    = bus.rdy & ~bus.rollback & (state_r != ST_FLUSH) & ((state_r == ST_IDLE) | fire_s);
        accept_s   = bus.in_valid & ready_s;
        {q1_s, v1_s} = resolve_operand(use1_r, rs1_r, bus.rf_rob_id1, bus.rf_val1,
                                       bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val);
        {q2_s, v2_s} = resolve_operand(use2_r, rs2_r, bus.rf_rob_id2, bus.rf_val2,
                                       bus.cdb_valid, bus.cdb_rob_pos, bus.cdb_val);
    end

    // Next-state logic; rollback always lands in FLUSH, even from FLUSH itself.
    always_comb begin
        state_nxt_s = state_r;
        if (!bus.rdy) begin
            state_nxt_s = state_r;
        end else if (bus.rollback) begin
            state_nxt_s = ST_FLUSH;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = accept_s ? ST_HOLD : ST_IDLE;
                ST_HOLD: begin
                    if (accept_s) begin
                        state_nxt_s = ST_HOLD;
                    end else if (fire_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_FLUSH: state_nxt_s = ST_IDLE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction buffer: loaded on accept, dropped on rollback.
    always_ff @(posedge clk) begin
        if (rst || (bus.rdy && bus.rollback)) begin
            op_r    <= '0;
            is_ls_r <= 1'b0;
            rd_r    <= 5'd0;
            rs1_r   <= 5'd0;
            rs2_r   <= 5'd0;
            use1_r  <= 1'b0;
            use2_r  <= 1'b0;
            imm_r   <= '0;
            pc_r    <= '0;
        end else if (accept_s) begin
            op_r    <= bus.in_op;
            is_ls_r <= bus.in_is_ls;
            rd_r    <= bus.in_rd;
            rs1_r   <= bus.in_rs1;
            rs2_r   <= bus.in_rs2;
            use1_r  <= bus.in_use_rs1;
            use2_r  <= bus.in_use_rs2;
            imm_r   <= bus.in_imm;
            pc_r    <= bus.in_pc;
        end
    end

    // Dispatch packet and issue counter; everything freezes while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_disp_r   <= 1'b0;
            lsb_disp_r  <= 1'b0;
            d_op_r      <= '0;
            d_imm_r     <= '0;
            d_pc_r      <= '0;
            d_rd_r      <= 5'd0;
            d_rob_pos_r <= '0;
            d_q1_r      <= '0;
            d_q2_r      <= '0;
            d_v1_r      <= '0;
            d_v2_r      <= '0;
            issue_cnt_r <= 32'd0;
        end else if (bus.rdy) begin
            rs_disp_r  <= fire_s & ~is_ls_r;
            lsb_disp_r <= fire_s & is_ls_r;
            if (fire_s) begin
                d_op_r      <= op_r;
                d_imm_r     <= imm_r;
                d_pc_r      <= pc_r;
                d_rd_r      <= rd_r;
                d_rob_pos_r <= bus.rob_tail;
                d_q1_r      <= q1_s;
                d_q2_r      <= q2_s;
                d_v1_r      <= v1_s;
                d_v2_r      <= v2_s;
                issue_cnt_r <= issue_cnt_r + 32'd1;
            end
        end
    end

    assign bus.in_ready         = ready_s;
    assign bus.rf_rs1           = rs1_r;
    assign bus.rf_rs2           = rs2_r;
    assign bus.rf_issue         = fire_s;
    assign bus.rf_issue_rd      = rd_r;
    assign bus.rf_issue_rob_pos = bus.rob_tail;
    assign bus.rs_disp          = rs_disp_r;
    assign bus.lsb_disp         = lsb_disp_r;
    assign bus.d_op             = d_op_r;
    assign bus.d_imm            = d_imm_r;
    assign bus.d_pc             = d_pc_r;
    assign bus.d_rd             = d_rd_r;
    assign bus.d_rob_pos        = d_rob_pos_r;
    assign bus.d_q1             = d_q1_r;
    assign bus.d_q2             = d_q2_r;
    assign bus.d_v1             = d_v1_r;
    assign bus.d_v2             = d_v2_r;
    assign bus.issue_cnt        = issue_cnt_r;
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Sits between the Decoder and the rename register file, reorder buffer (ROB), reservation station (RS) and load/store buffer (LSB).
- Holds one decoded instruction and waits until a ROB slot and its target queue both have room.
- In the issue cycle it reads operand rename state from the register file, forwards any same-cycle CDB result, drives the register-file rename (issue) port and the ROB allocation.
- One cycle later it presents a registered dispatch packet to the RS or the LSB.
- Rollback drops the held instruction and inserts a one-cycle flush bubble.

Parameters:
DATA_W, 32, operand/immediate/pc width
ROB_POS_W, 4, ROB index width (rename tag = {busy flag, pos}, ROB_POS_W+1 bits)
OP_W, 6, opaque opcode width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when low all state frozen, rf_issue=0, in_ready=0
rollback  in  1  misprediction flush
in_valid  in  1  Decoder has instruction
in_ready  out  1  scheduler accepts this cycle
in_op  in  OP_W  opcode
in_is_ls  in  1  1=to LSB, 0=to RS
in_rd/in_rs1/in_rs2  in  5 each  register indices
in_use_rs1/in_use_rs2  in  1 each  operand used
in_imm/in_pc  in  DATA_W each
rob_full  in  1
rob_tail  in  ROB_POS_W  slot allocated on fire
rs_full/lsb_full  in  1 each
rf_rs1/rf_rs2  out  5 each  combinational query = held rs1/rs2
rf_val1/rf_val2  in  DATA_W each
rf_rob_id1/rf_rob_id2  in  ROB_POS_W+1 each
rf_issue  out  1  rename strobe (= fire); also ROB alloc
rf_issue_rd  out  5
rf_issue_rob_pos  out  ROB_POS_W  = rob_tail
cdb_valid  in  1
cdb_rob_pos  in  ROB_POS_W
cdb_val  in  DATA_W
rs_disp/lsb_disp  out  1 each  registered one-cycle dispatch strobes
d_op/d_imm/d_pc/d_rd/d_rob_pos  out  registered packet fields
d_q1/d_q2  out  ROB_POS_W+1 each  0 = value ready
d_v1/d_v2  out  DATA_W each
issue_cnt  out  32  instructions issued since reset

Behaviour:
- States: IDLE (buffer empty), HOLD (buffer full), FLUSH. Reset → IDLE. All outputs, buffer and issue_cnt reset to 0.
- fire = rdy & state==HOLD & !rollback & !rob_full & !(in_is_ls_held ? lsb_full : rs_full).
- in_ready = rdy & !rollback & state!=FLUSH & (state==IDLE | fire).
- Accept (in_valid & in_ready) loads the buffer; the next state is HOLD.
- HOLD & fire & no accept → IDLE. Fire and accept in the same cycle gives back-to-back issue, one instruction per cycle maximum.
- Operand X at fire:
  - use_rsX=0 or rsX=0 → q=0, v=0.
  - Else if rf_rob_idX[MSB]=1, cdb_valid, and the low bits equal cdb_rob_pos → q=0, v=cdb_val.
  - Else q=rf_rob_idX, v=rf_valX.
  - The register file itself already forwards a same-cycle commit.
- Operands are sampled only in the fire cycle, never while waiting in HOLD.
- Dispatch packet: registered at the fire edge. rs_disp or lsb_disp is high for exactly the following cycle. The other strobe stays 0, and both are 0 in any non-fire cycle. Fields hold their values when the strobes are low.
- rf_issue_rd is the held rd, including rd=0; the register file ignores rd=0.
- issue_cnt increments on fire, wrapping modulo 2^32.
- rollback (with rdy): forces fire=0 and in_ready=0. Clears the buffer and the next-cycle dispatch strobes. State → FLUSH.
- FLUSH: lasts exactly one cycle, then IDLE. This cycle is required because the register file clears its tags on the rollback edge.
- A rollback arriving during FLUSH restarts FLUSH.
- rst overrides rollback and rdy.
- rdy low: no transitions, strobes held at their registered values.

Test Plan:
- Reset, then in_valid with rd=5, rs1=1 (rob_id1=0, val1=7), rob_tail=3 → rf_issue pulses with rob_pos=3 in the cycle after accept. Next cycle rs_disp=1, d_q1=0, d_v1=7, d_rob_pos=3, issue_cnt=1.
- rs_full=1 for 4 cycles while holding → in_ready=0 and no rf_issue. When rs_full drops → fire; at that cycle rf_rob_id1=0x12 and cdb_valid with pos 2 and val 0xAB → d_q1=0, d_v1=0xAB.
- Stream of 3 instructions with no back-pressure → rf_issue high for 3 consecutive cycles, rs_disp/lsb_disp on the following 3 cycles, issue_cnt=3.
- in_is_ls=1 with lsb_full=1 and rs_full=0 → no fire. Release lsb_full → lsb_disp=1, rs_disp=0.
- rollback while in HOLD with fire conditions met → no rf_issue and no dispatch. The next cycle is FLUSH with in_ready=0 even though in_valid=1. Acceptance resumes one cycle later.
- rdy=0 for 3 cycles mid-HOLD → state, issue_cnt and outputs unchanged. rst asserted mid-HOLD → all outputs 0 next cycle, state IDLE.
